// File: rtl/fib_result_buffer.sv
// Result FIFO behind the Fibonacci generator: captures single-cycle result pulses,
// re-presents them on valid/ready, and counts results dropped while full.
module fib_result_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fib_valid_in,
  input  logic [DATA_W-1:0]          fib_data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_count,
  input  logic                       clear_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  drop_count_q;

  logic pop;
  logic push;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Status decode: purely from registered state.
  assign empty      = (level_q == '0);
  assign full       = (level_q == LVL_W'(DEPTH));
  assign level      = level_q;
  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem[rd_ptr];
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

  // A pop in the same cycle frees a slot on a full FIFO, so the push is kept.
  assign pop  = out_valid & out_ready;
  assign push = fib_valid_in & (!full | pop);
  assign drop = fib_valid_in & full & !pop;

  // Storage: data only, never reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= fib_data_in;
    end
  end

  // Pointer and occupancy control.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Drop bookkeeping: a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q   <= 1'b1;
      drop_count_q <= clear_overflow ? CNT_W'(1) : sat_inc(drop_count_q);
    end else if (clear_overflow) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end
  end

endmodule
